// File: rtl/leb128_fetch_if.sv
// Byte-wide ROM read bus. The LEB128 fetch engine is the master and the ROM
// responder is the slave: address and read enable flow out, data and a
// one-cycle ready pulse flow back.
interface leb128_fetch_if;
  logic [31:0] rom_addr;
  logic        rom_read_en;
  logic [7:0]  rom_data_in;
  logic        rom_ready;

  modport master (
    output rom_addr,
    output rom_read_en,
    input  rom_data_in,
    input  rom_ready
  );

  modport slave (
    input  rom_addr,
    input  rom_read_en,
    output rom_data_in,
    output rom_ready
  );
endinterface

// File: rtl/leb128_fetch.sv
// LEB128 fetch/decode engine. Walks the ROM one byte at a time and decodes a
// single unsigned or signed 32-bit LEB128 integer per request. A one-entry
// cache of the last fetched byte covers the ROM's "answer only on address
// change" behaviour, and a dummy read of address 1 is issued before the first
// read of address 0 after reset because the ROM's last-address register
// starts at 0.
module leb128_fetch #(
  parameter int MAX_BYTES = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [31:0]    i_start_addr,
  input  logic           i_signed_mode,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error,
  output logic [31:0]    o_value,
  output logic [2:0]     o_length,
  output logic [31:0]    o_next_addr,
  leb128_fetch_if.master rom
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  LAST_IDX = 3'(MAX_BYTES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;

  logic [31:0]   r_cur_addr;
  logic [31:0]   r_start_addr;
  logic [31:0]   r_acc;
  logic [2:0]    r_idx;
  logic          r_signed;
  logic [CW-1:0] r_wait_cnt;
  logic          r_cache_valid;
  logic [31:0]   r_cache_addr;
  logic [7:0]    r_cache_data;
  logic          r_prime_needed;
  logic          r_priming;
  logic [31:0]   r_value;
  logic [2:0]    r_length;
  logic [31:0]   r_next_addr;
  logic          r_error;

  logic          w_hit;
  logic [7:0]    w_byte;
  logic [5:0]    w_shamt;
  logic [5:0]    w_ext_shamt;
  logic [31:0]   w_acc_or;
  logic [31:0]   w_acc_new;
  logic          w_final;
  logic          w_top_group;
  logic          w_ovf;
  logic          w_ext;
  logic [31:0]   w_rom_addr;

  logic          w_accept;
  logic          w_consume;
  logic          w_advance;
  logic          w_finish;
  logic          w_fin_err;
  logic [2:0]    w_fin_len;
  logic [31:0]   w_fin_acc;
  logic          w_rom_read_en;
  logic          w_busy;
  logic          w_done;

  // The cached byte stands in for a fetch only when it was read from exactly
  // the address we are about to read.
  assign w_hit      = r_cache_valid && (r_cache_addr == r_cur_addr);
  assign w_byte     = (r_state == S_WAIT) ? rom.rom_data_in : r_cache_data;
  assign w_rom_addr = r_priming ? 32'd1 : r_cur_addr;

  // Byte accumulation: 7 payload bits per group; at group 4 the shift pushes
  // bits above 31 out of the word.
  assign w_shamt     = {3'd0, r_idx} * 6'd7;
  assign w_ext_shamt = w_shamt + 6'd7;
  assign w_acc_or    = r_acc | ({25'd0, w_byte[6:0]} << w_shamt);
  assign w_final     = ~w_byte[7];
  assign w_top_group = (r_idx == 3'd4);
  // Fifth group of a u32 may only carry 4 bits; for s32 the dropped bits must
  // all equal the sign bit (bit 3 of the group).
  assign w_ovf       = w_final && w_top_group &&
                       (r_signed ? !((w_byte[6:3] == 4'h0) || (w_byte[6:3] == 4'hF))
                                 : (w_byte[6:4] != 3'd0));
  assign w_ext       = r_signed && w_final && w_byte[6] && (r_idx < 3'd4);
  assign w_acc_new   = w_ext ? (w_acc_or | (32'hFFFF_FFFF << w_ext_shamt)) : w_acc_or;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode, including what happens to a byte once it
  // is in hand (fetched in WAIT or cached in REQ).
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_consume     = 1'b0;
    w_advance     = 1'b0;
    w_finish      = 1'b0;
    w_fin_err     = 1'b0;
    w_fin_len     = r_idx;
    w_fin_acc     = r_acc;
    w_rom_read_en = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = (r_prime_needed && (i_start_addr == 32'd0)) ? S_PRIME : S_REQ;
        end
      end
      S_PRIME: begin
        w_busy        = 1'b1;
        w_rom_read_en = 1'b1;
        w_state_next  = S_WAIT;
      end
      S_REQ: begin
        w_busy = 1'b1;
        if (w_hit) begin
          w_consume = 1'b1;
        end else begin
          w_rom_read_en = 1'b1;
          w_state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy        = 1'b1;
        w_rom_read_en = 1'b1;
        if (rom.rom_ready) begin
          if (r_priming) begin
            w_state_next = S_REQ;
          end else begin
            w_consume = 1'b1;
          end
        end else if (r_wait_cnt == TMO_LAST) begin
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_consume) begin
      w_fin_acc = w_acc_new;
      w_fin_len = r_idx + 3'd1;
      if (w_final) begin
        w_finish     = 1'b1;
        w_fin_err    = w_ovf;
        w_state_next = S_DONE;
      end else if (r_idx == LAST_IDX) begin
        w_finish     = 1'b1;
        w_fin_err    = 1'b1;
        w_state_next = S_DONE;
      end else begin
        w_advance    = 1'b1;
        w_state_next = S_REQ;
      end
    end
  end

  // Datapath: request latch, wait counter, byte cache, accumulator and the
  // held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr     <= 32'd0;
      r_start_addr   <= 32'd0;
      r_acc          <= 32'd0;
      r_idx          <= 3'd0;
      r_signed       <= 1'b0;
      r_wait_cnt     <= '0;
      r_cache_valid  <= 1'b0;
      r_cache_addr   <= 32'd0;
      r_cache_data   <= 8'd0;
      r_prime_needed <= 1'b1;
      r_priming      <= 1'b0;
      r_value        <= 32'd0;
      r_length       <= 3'd0;
      r_next_addr    <= 32'd0;
      r_error        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_addr   <= i_start_addr;
        r_start_addr <= i_start_addr;
        r_acc        <= 32'd0;
        r_idx        <= 3'd0;
        r_error      <= 1'b0;
        r_signed     <= i_signed_mode;
        r_priming    <= r_prime_needed && (i_start_addr == 32'd0);
      end

      if ((r_state == S_PRIME) || ((r_state == S_REQ) && !w_hit)) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_WAIT) && !rom.rom_ready) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end

      // Every completed read, priming included, refreshes the cache so it
      // always mirrors the ROM's last-address register.
      if ((r_state == S_WAIT) && rom.rom_ready) begin
        r_cache_valid  <= 1'b1;
        r_cache_addr   <= w_rom_addr;
        r_cache_data   <= rom.rom_data_in;
        r_prime_needed <= 1'b0;
        r_priming      <= 1'b0;
      end

      if (w_consume) begin
        r_acc <= w_acc_new;
      end

      if (w_advance) begin
        r_idx      <= r_idx + 3'd1;
        r_cur_addr <= r_cur_addr + 32'd1;
      end

      if (w_finish) begin
        r_value     <= w_fin_acc;
        r_length    <= w_fin_len;
        r_next_addr <= r_start_addr + {29'd0, w_fin_len};
        r_error     <= w_fin_err;
      end
    end
  end

  assign o_busy          = w_busy;
  assign o_done          = w_done;
  assign o_error         = r_error;
  assign o_value         = r_value;
  assign o_length        = r_length;
  assign o_next_addr     = r_next_addr;
  assign rom.rom_addr    = w_rom_addr;
  assign rom.rom_read_en = w_rom_read_en;

endmodule

// File: tb/tb_leb128_fetch.sv
// Testbench for leb128_fetch: directed cases plus random decodes of a random
// ROM image, checked against an arithmetic LEB128 reference and a simple model
// of which addresses must actually be read from the ROM.
module tb_leb128_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = 32'd0;
  logic        signed_mode = 1'b0;
  logic        busy, done, error;
  logic [31:0] value, next_addr;
  logic [2:0]  length;

  leb128_fetch_if rom_if ();

  logic [7:0]  mem [256];
  logic        rom_mute = 1'b0;
  logic [31:0] rom_last;

  int n_checks = 0;
  int n_fail   = 0;

  // reference-side knowledge of what the ROM last returned
  bit          m_cache_valid  = 1'b0;
  logic [31:0] m_cache_addr   = 32'd0;
  bit          m_prime_needed = 1'b1;

  // results of the last run
  logic [31:0] g_val, g_len, g_next, g_err;
  int          g_cyc, g_bur;
  bit          g_saw1, g_got;

  leb128_fetch #(.MAX_BYTES(5), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_signed_mode(signed_mode),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_value      (value),
    .o_length     (length),
    .o_next_addr  (next_addr),
    .rom          (rom_if.master)
  );

  always #5 clk = ~clk;

  // ROM responder: answers one cycle after a read of a new address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_last              <= 32'd0;
      rom_if.rom_ready      <= 1'b0;
      rom_if.rom_data_in    <= 8'd0;
    end else if (!rom_mute && rom_if.rom_read_en && (rom_if.rom_addr != rom_last)) begin
      rom_last              <= rom_if.rom_addr;
      rom_if.rom_ready      <= 1'b1;
      rom_if.rom_data_in    <= mem[rom_if.rom_addr[7:0]];
    end else begin
      rom_if.rom_ready      <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // LEB128 reference with plain integer arithmetic
  function automatic void ref_decode(input logic [31:0] a, input bit sgn,
                                     output logic [31:0] v, output int len, output bit err);
    longint    acc = 0;
    bit        fin = 1'b0;
    logic [7:0] b;
    len = 0;
    while (len < 5 && !fin) begin
      b   = mem[8'(a + 32'(len))];
      acc = acc + (longint'(b & 8'h7F) << (7 * len));
      len++;
      fin = !b[7];
    end
    if (!fin) begin
      err = 1'b1;
    end else if (sgn) begin
      if (acc[7*len-1]) acc = acc - (longint'(1) << (7 * len));
      err = (acc < -64'sd2147483648) || (acc > 64'sd2147483647);
    end else begin
      err = (acc > 64'sd4294967295);
    end
    v = acc[31:0];
  endfunction

  // One request; cycle 0 is the cycle start is sampled, g_cyc is the done cycle.
  task automatic run(input logic [31:0] a, input bit sgn, input bit poke_done);
    bit          prev_en = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    g_bur = 0; g_saw1 = 1'b0; g_got = 1'b0; g_cyc = 0;
    @(negedge clk);
    start = 1'b1; start_addr = a; signed_mode = sgn;
    @(negedge clk);
    start = 1'b0; g_cyc = 1;
    for (int k = 0; k < 200 && !g_got; k++) begin
      if (rom_if.rom_read_en && (!prev_en || rom_if.rom_addr != prev_addr)) g_bur++;
      if (rom_if.rom_read_en && rom_if.rom_addr == 32'd1) g_saw1 = 1'b1;
      prev_en   = rom_if.rom_read_en;
      prev_addr = rom_if.rom_addr;
      if (done) begin
        g_got = 1'b1;
      end else begin
        @(negedge clk);
        g_cyc++;
      end
    end
    check("done seen", 32'(g_got), 32'd1);
    g_val = value; g_len = 32'(length); g_next = next_addr; g_err = 32'(error);
    $display("decode addr=0x%08h signed=%0d -> value=0x%08h len=%0d next=0x%08h err=%0d cyc=%0d bursts=%0d",
             a, sgn, g_val, g_len, g_next, g_err, g_cyc, g_bur);
    if (poke_done && g_got) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start in DONE ignored", 32'(busy), 32'd0);
    end
  endtask

  task automatic decode_check(input string tag, input logic [31:0] a, input bit sgn, input bit poke);
    logic [31:0] ev;
    int          elen, ecyc, ebur;
    bit          eerr;
    ref_decode(a, sgn, ev, elen, eerr);
    ecyc = 1; ebur = 0;
    if (m_prime_needed && a == 32'd0) begin
      ecyc += 2; ebur++;
      m_cache_valid = 1'b1; m_cache_addr = 32'd1; m_prime_needed = 1'b0;
    end
    for (int i = 0; i < elen; i++) begin
      if (m_cache_valid && m_cache_addr == a + 32'(i)) begin
        ecyc += 1;
      end else begin
        ecyc += 2; ebur++;
        m_cache_valid = 1'b1; m_cache_addr = a + 32'(i); m_prime_needed = 1'b0;
      end
    end
    run(a, sgn, poke);
    check({tag, " value"},  g_val,  ev);
    check({tag, " length"}, g_len,  32'(elen));
    check({tag, " next"},   g_next, a + 32'(elen));
    check({tag, " error"},  g_err,  32'(eerr));
    check({tag, " cycles"}, 32'(g_cyc), 32'(ecyc));
    check({tag, " fetches"}, 32'(g_bur), 32'(ebur));
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = {1'($urandom_range(0, 1)), 7'($urandom)};
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h77;
    mem[8'h10] = 8'hE5; mem[8'h11] = 8'h8E; mem[8'h12] = 8'h26;
    mem[8'h20] = 8'h7F; mem[8'h21] = 8'h08;
    mem[8'h30] = 8'hFF; mem[8'h31] = 8'hFF; mem[8'h32] = 8'hFF; mem[8'h33] = 8'hFF; mem[8'h34] = 8'h0F;
    for (int i = 8'h40; i < 8'h45; i++) mem[i] = 8'hFF;
    mem[8'hFE] = 8'h81; mem[8'hFF] = 8'h82;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset value", value, 32'd0);
    check("reset length", 32'(length), 32'd0);
    check("reset next_addr", next_addr, 32'd0);
    check("reset rom_addr", rom_if.rom_addr, 32'd0);
    check("reset rom_read_en", 32'(rom_if.rom_read_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // first read of address 0 needs the priming read of address 1
    decode_check("prime 0x00", 32'h0, 1'b0, 1'b0);
    check("prime addr1 seen", 32'(g_saw1), 32'd1);
    check("prime value const", g_val, 32'd5);

    decode_check("0x10 u", 32'h10, 1'b0, 1'b1);
    check("0x10 value const", g_val, 32'h0009_8765);
    check("0x10 bursts const", 32'(g_bur), 32'd3);

    decode_check("0x20 s", 32'h20, 1'b1, 1'b0);
    check("0x20 s value const", g_val, 32'hFFFF_FFFF);
    decode_check("0x20 u cached", 32'h20, 1'b0, 1'b0);
    check("0x20 u value const", g_val, 32'h7F);
    decode_check("0x20 u again", 32'h20, 1'b0, 1'b0);
    check("re-decode no fetch", 32'(g_bur), 32'd0);
    check("re-decode cycles", 32'(g_cyc), 32'd2);
    decode_check("0x21 u", 32'h21, 1'b0, 1'b0);
    check("0x21 cycles const", 32'(g_cyc), 32'd3);

    decode_check("0x30 5B", 32'h30, 1'b0, 1'b0);
    check("0x30 value const", g_val, 32'hFFFF_FFFF);
    check("0x30 error const", g_err, 32'd0);
    decode_check("0x40 cont", 32'h40, 1'b0, 1'b0);
    check("0x40 error const", g_err, 32'd1);
    check("0x40 length const", g_len, 32'd5);
    mem[8'h34] = 8'h1F;
    decode_check("0x30 ovf", 32'h30, 1'b0, 1'b0);
    check("0x30 ovf error const", g_err, 32'd1);

    decode_check("wrap", 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("wrap next const", g_next, 32'd1);

    // random decodes over a random image, sometimes restarting on the cached byte
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0 && m_cache_valid) ra = m_cache_addr;
      else ra = 32'h80 + 32'($urandom_range(0, 'h6B));
      decode_check("rand", ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a fetch
    decode_check("pre-reset 0x21", 32'h21, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; start_addr = 32'h10; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid-wait read_en", 32'(rom_if.rom_read_en), 32'd1);
    rst = 1'b1;
    #1;
    check("async busy", 32'(busy), 32'd0);
    check("async done", 32'(done), 32'd0);
    check("async error", 32'(error), 32'd0);
    check("async value", value, 32'd0);
    check("async length", 32'(length), 32'd0);
    check("async next_addr", next_addr, 32'd0);
    check("async rom_addr", rom_if.rom_addr, 32'd0);
    check("async rom_read_en", 32'(rom_if.rom_read_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cache_valid = 1'b0; m_prime_needed = 1'b1;
    decode_check("post-reset 0x21", 32'h21, 1'b0, 1'b0);
    check("post-reset real fetch", 32'(g_bur), 32'd1);

    // silent ROM: abort after TIMEOUT wait cycles
    rom_mute = 1'b1;
    run(32'h50, 1'b0, 1'b0);
    check("timeout error", g_err, 32'd1);
    check("timeout cycles", 32'(g_cyc), 32'd18);
    check("timeout length", g_len, 32'd0);
    check("timeout next", g_next, 32'h50);
    rom_mute = 1'b0;
    decode_check("after timeout 0x21", 32'h21, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/leb128_fetch.md
Name: leb128_fetch

Overview:
- Bus initiator that walks the byte-wide ROM read interface and decodes one LEB128 integer (u32 or s32) per request.
- Sits between the wasm loader's section/opcode parser and the ROM responder.
- Returns the decoded value, its encoded length and the next address.
- Owns the ROM's "only respond on address change" rule, so callers may re-decode the same address back-to-back.

Parameters:
- MAX_BYTES, 5, maximum encoded bytes accepted before flagging overflow (u32/s32 = 5)
- TIMEOUT, 16, cycles to wait for rom_ready on one fetch before aborting with error

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- start_addr  in  32  ROM address of first encoded byte
- signed_mode  in  1  0 = unsigned LEB128, 1 = signed (sign-extend to 32 bits)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the result is valid
- error  out  1  valid with done: overflow or timeout
- value  out  32  decoded integer, held until next accepted start
- length  out  3  bytes consumed (1..MAX_BYTES), held
- next_addr  out  32  start_addr + length, held
- rom_addr  out  32  ROM read address
- rom_read_en  out  1  ROM read request
- rom_data_in  in  8  ROM byte
- rom_ready  in  1  ROM one-cycle data-valid pulse

Behaviour:
- Reset (async, any state): state = IDLE; busy = done = error = rom_read_en = 0; value = length = next_addr = rom_addr = 0; cache invalid; prime_needed = 1.
- States: IDLE, PRIME, REQ, WAIT, DONE.
- IDLE
  - start = 1: latch start_addr to cur_addr; clear acc, idx and error.
  - If cache valid and cache_addr == cur_addr, use the cached byte in place of a fetch.
  - Else if prime_needed and cur_addr == 0, go to PRIME.
  - Else go to REQ.
- PRIME: read address 1 through the same REQ/WAIT handshake and discard the byte. Reason: the ROM's last-address register resets to 0 and would never answer a first read of 0. Clear prime_needed, then go to REQ.
- REQ: drive rom_addr = cur_addr, rom_read_en = 1; go to WAIT and clear the wait counter.
- WAIT
  - Hold rom_read_en = 1 and rom_addr stable.
  - On rom_ready = 1: capture rom_data_in, drop rom_read_en next cycle, and load the cache with cur_addr and the byte.
  - Any completed fetch clears prime_needed.
  - Counter reaching TIMEOUT: error = 1, go to DONE.
- Byte processing (fetched or cached byte b):
  - acc |= b[6:0] << (7*idx).
  - At idx = 4, bits above 31 are discarded.
  - If b[7] = 0: final byte, length = idx + 1, go to DONE.
  - Else if idx + 1 == MAX_BYTES: error = 1, go to DONE.
  - Else idx++, cur_addr++, and re-check the cache, then go to REQ.
- Overflow: in unsigned mode, final byte at idx 4 with b[6:4] != 0 sets error. In signed mode, b[6:3] must be all 0 or all 1, else error.
- Sign extension: signed_mode and final b[6] = 1 and 7*(idx+1) < 32 fill acc[31:7*(idx+1)] with 1s.
- DONE: done = 1 for exactly one cycle; value = acc; next_addr = start_addr + length; busy = 0; go to IDLE.
- On error, value/length/next_addr reflect the bytes consumed so far.
- Latency: 2 cycles per ROM fetch plus 1 for DONE. A single uncached byte gives start at cycle 0, rom_read_en at cycle 1, rom_ready at cycle 2, done at cycle 3. A cached byte adds 0 fetch cycles.
- start while busy is ignored. start in the same cycle as the done pulse is ignored (state is DONE, not IDLE).
- Address arithmetic wraps at 2^32 with no error.

Test Plan:
- ROM[0x10..0x12] = E5 8E 26, unsigned, start_addr = 0x10 -> done with value = 0x00098765 (624485), length = 3, next_addr = 0x13, error = 0, three rom_read_en bursts.
- ROM[0x20] = 0x7F, signed -> value = 0xFFFFFFFF, length = 1. Same byte unsigned -> value = 0x7F. ROM[0x21] = 0x08 -> value = 8, done exactly 3 cycles after start.
- Re-decode 0x20 immediately after decoding 0x20 -> no rom_read_en asserted, same value, done 2 cycles after start.
- ROM[0x30..0x34] = FF FF FF FF 0F, unsigned -> value = 0xFFFFFFFF, length = 5, error = 0. With ROM[0x34] = 0x1F -> error = 1. ROM[0x40..0x44] all 0xFF -> error = 1, length = 5.
- First request after reset at start_addr = 0, ROM[0] = 0x05 -> priming read of address 1 observed, then value = 5. rom_ready forced 0 -> error = 1 with done pulse after TIMEOUT (16) wait cycles.
- Assert rst mid-WAIT -> all outputs 0 within the same cycle. A following start at a previously cached address performs a real ROM fetch (cache invalidated).
